// File: rtl/inventory_keeper_if.sv
// Bundle of the sale, restock handshake and stock-report signals that pass
// between the inventory keeper and its users (vending FSM, service port).
// master: the requesting side (drives sale/restock inputs); slave: the keeper.
interface inventory_keeper_if;
   logic       decrement;     // sale strobe, level, one sale per rising edge
   logic [7:0] item_code;     // item being sold
   logic       restock_req;   // restock request, held until restock_ack
   logic [7:0] restock_code;  // item being restocked
   logic [2:0] restock_qty;   // units to add
   logic       restock_ack;   // restock acknowledge
   logic [2:0] cs_pc;         // potato chips count
   logic [2:0] cs_cb;         // candy bar count
   logic [2:0] cs_s;          // soda count
   logic [2:0] cs_c;          // cookie count
   logic [3:0] low_stock;     // {cookie, soda, candy, chips} at or below threshold
   logic       vend_err;      // illegal sale pulse
   logic       restock_err;   // unknown restock code pulse
   logic [7:0] sold_total;    // successful sales since reset, wrapping

   modport master (
      output decrement, item_code, restock_req, restock_code, restock_qty,
      input  restock_ack, cs_pc, cs_cb, cs_s, cs_c, low_stock, vend_err,
             restock_err, sold_total
   );

   modport slave (
      input  decrement, item_code, restock_req, restock_code, restock_qty,
      output restock_ack, cs_pc, cs_cb, cs_s, cs_c, low_stock, vend_err,
             restock_err, sold_total
   );
endinterface

// File: rtl/inventory_keeper.sv
// Per-item stock counter for the vending machine: one unit removed per sale
// edge, restock via a req/ack handshake, error pulses, low-stock flags, sales total.
// Ports: clk, reset (async active-low), bus (inventory_keeper_if.slave).
module inventory_keeper #(
   parameter logic [2:0] INIT_COUNT = 3'd5,
   parameter logic [2:0] LOW_THRESH = 3'd1
) (
   input logic              clk,
   input logic              reset,
   inventory_keeper_if.slave bus
);

   typedef enum logic [1:0] {R_IDLE, R_APPLY, R_ACK} r_state_t;

   // Item encoding -> {valid, index}; index 0 chips, 1 candy, 2 soda, 3 cookie.
   function automatic logic [2:0] decode(input logic [7:0] code);
      case (code)
         8'hA2:   decode = 3'b100;
         8'hB3:   decode = 3'b101;
         8'hD5:   decode = 3'b110;
         8'hE8:   decode = 3'b111;
         default: decode = 3'b000;
      endcase
   endfunction

   r_state_t   state, state_nxt;
   logic [2:0] cnt [4];
   logic       dec_prev;
   logic       restock_ack_q, vend_err_q, restock_err_q;
   logic [7:0] sold_total_q;

   logic       sale_evt, s_vld, r_vld, sale_ok, conflict, rs_do;
   logic [1:0] s_idx, r_idx;
   logic [3:0] rs_sum;
   logic [2:0] rs_val;

   always_comb begin
      {s_vld, s_idx} = decode(bus.item_code);
      {r_vld, r_idx} = decode(bus.restock_code);
      sale_evt = bus.decrement & ~dec_prev;
      sale_ok  = sale_evt & s_vld & (cnt[s_idx] != 3'd0);
      // A sale edge on the item being restocked wins; the restock waits a cycle.
      conflict = sale_evt & s_vld & r_vld & (s_idx == r_idx);
      // Add in 4 bits so an overflow past 7 can be caught and clamped.
      rs_sum   = {1'b0, cnt[r_idx]} + {1'b0, bus.restock_qty};
      rs_val   = rs_sum[3] ? 3'd7 : rs_sum[2:0];
   end

   // Restock handshake next-state logic.
   always_comb begin
      state_nxt = state;
      rs_do     = 1'b0;
      case (state)
         R_IDLE:  if (bus.restock_req) state_nxt = R_APPLY;
         R_APPLY: if (!conflict) begin
                     rs_do     = 1'b1;
                     state_nxt = R_ACK;
                  end
         R_ACK:   if (!bus.restock_req) state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= R_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) cnt[i] <= INIT_COUNT;
         dec_prev      <= 1'b0;
         restock_ack_q <= 1'b0;
         vend_err_q    <= 1'b0;
         restock_err_q <= 1'b0;
         sold_total_q  <= 8'd0;
      end else begin
         dec_prev      <= bus.decrement;
         // Ack is registered from the next state so it is high exactly while in R_ACK.
         restock_ack_q <= (state_nxt == R_ACK);
         vend_err_q    <= sale_evt & ~sale_ok;
         restock_err_q <= rs_do & ~r_vld;
         sold_total_q  <= sold_total_q + {7'd0, sale_ok};
         // Sale and restock never hit the same index in one cycle (conflict defers it).
         for (int i = 0; i < 4; i++) begin
            if (sale_ok && s_idx == 2'(i))
               cnt[i] <= cnt[i] - 3'd1;
            else if (rs_do && r_vld && r_idx == 2'(i))
               cnt[i] <= rs_val;
         end
      end
   end

   always_comb begin
      bus.restock_ack = restock_ack_q;
      bus.vend_err    = vend_err_q;
      bus.restock_err = restock_err_q;
      bus.sold_total  = sold_total_q;
      bus.cs_pc       = cnt[0];
      bus.cs_cb       = cnt[1];
      bus.cs_s        = cnt[2];
      bus.cs_c        = cnt[3];
      for (int i = 0; i < 4; i++) bus.low_stock[i] = (cnt[i] <= LOW_THRESH);
   end

endmodule

// File: tb/tb_inventory_keeper.sv
// Directed self-checking bench for inventory_keeper.
// Inputs change just after a falling edge; outputs are checked at falling edges.
module tb_inventory_keeper;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   inventory_keeper_if ifc ();

   inventory_keeper dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_counts(input string tag, input logic [2:0] pc, input logic [2:0] cb,
                               input logic [2:0] s, input logic [2:0] c);
      check({tag, " cs_pc"}, {5'd0, ifc.cs_pc}, {5'd0, pc});
      check({tag, " cs_cb"}, {5'd0, ifc.cs_cb}, {5'd0, cb});
      check({tag, " cs_s"},  {5'd0, ifc.cs_s},  {5'd0, s});
      check({tag, " cs_c"},  {5'd0, ifc.cs_c},  {5'd0, c});
   endtask

   initial begin
      reset            = 1'b0;
      ifc.decrement    = 1'b0;
      ifc.item_code    = 8'h00;
      ifc.restock_req  = 1'b0;
      ifc.restock_code = 8'h00;
      ifc.restock_qty  = 3'd0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Reset state
      check_counts("reset", 3'd5, 3'd5, 3'd5, 3'd5);
      check("reset sold_total", ifc.sold_total, 8'd0);
      check("reset low_stock", {4'd0, ifc.low_stock}, 8'h00);
      check("reset ack", {7'd0, ifc.restock_ack}, 8'd0);
      check("reset vend_err", {7'd0, ifc.vend_err}, 8'd0);

      // Chips sale held three cycles: only one decrement
      ifc.item_code = 8'hA2;
      ifc.decrement = 1'b1;
      tick();
      check("chips first cs_pc", {5'd0, ifc.cs_pc}, 8'd4);
      check("chips first sold", ifc.sold_total, 8'd1);
      check("chips first vend_err", {7'd0, ifc.vend_err}, 8'd0);
      tick();
      check("chips held cs_pc", {5'd0, ifc.cs_pc}, 8'd4);
      check("chips held vend_err", {7'd0, ifc.vend_err}, 8'd0);
      tick();
      ifc.decrement = 1'b0;
      tick();
      check("chips after cs_pc", {5'd0, ifc.cs_pc}, 8'd4);
      check("chips after sold", ifc.sold_total, 8'd1);

      // Five soda sales down to zero, low flag once count <= 1
      ifc.item_code = 8'hD5;
      for (int k = 1; k <= 5; k++) begin
         ifc.decrement = 1'b1;
         tick();
         ifc.decrement = 1'b0;
         check($sformatf("soda sale %0d cs_s", k), {5'd0, ifc.cs_s}, 8'(5 - k));
         check($sformatf("soda sale %0d low", k), {7'd0, ifc.low_stock[2]}, {7'd0, (5 - k) <= 1});
         tick();
      end
      check("soda sold", ifc.sold_total, 8'd6);
      // Sixth sale on empty soda
      ifc.decrement = 1'b1;
      tick();
      ifc.decrement = 1'b0;
      check("soda empty vend_err", {7'd0, ifc.vend_err}, 8'd1);
      check("soda empty cs_s", {5'd0, ifc.cs_s}, 8'd0);
      check("soda empty sold", ifc.sold_total, 8'd6);
      tick();
      check("soda empty err drop", {7'd0, ifc.vend_err}, 8'd0);
      check("low_stock soda only", {4'd0, ifc.low_stock}, 8'h04);

      // Unknown sale code
      ifc.item_code = 8'h11;
      ifc.decrement = 1'b1;
      tick();
      ifc.decrement = 1'b0;
      check("bad code vend_err", {7'd0, ifc.vend_err}, 8'd1);
      check("bad code sold", ifc.sold_total, 8'd6);
      check_counts("bad code", 3'd4, 3'd5, 3'd0, 3'd5);
      tick();
      check("bad code err drop", {7'd0, ifc.vend_err}, 8'd0);

      // Restock candy +6 saturates at 7
      ifc.restock_req  = 1'b1;
      ifc.restock_code = 8'hB3;
      ifc.restock_qty  = 3'd6;
      tick();
      check("candy apply ack", {7'd0, ifc.restock_ack}, 8'd0);
      tick();
      check("candy cs_cb", {5'd0, ifc.cs_cb}, 8'd7);
      check("candy ack", {7'd0, ifc.restock_ack}, 8'd1);
      check("candy restock_err", {7'd0, ifc.restock_err}, 8'd0);
      ifc.restock_code = 8'hE8;     // ignored outside R_APPLY
      ifc.restock_qty  = 3'd1;
      tick();
      check("candy ack held", {7'd0, ifc.restock_ack}, 8'd1);
      check_counts("candy held", 3'd4, 3'd7, 3'd0, 3'd5);
      ifc.restock_req = 1'b0;
      tick();
      check("candy ack drop", {7'd0, ifc.restock_ack}, 8'd0);

      // Unknown restock code: error pulse, still acknowledged
      ifc.restock_req  = 1'b1;
      ifc.restock_code = 8'h00;
      ifc.restock_qty  = 3'd3;
      tick();
      tick();
      check("bad restock err", {7'd0, ifc.restock_err}, 8'd1);
      check("bad restock ack", {7'd0, ifc.restock_ack}, 8'd1);
      check_counts("bad restock", 3'd4, 3'd7, 3'd0, 3'd5);
      tick();
      check("bad restock err drop", {7'd0, ifc.restock_err}, 8'd0);
      ifc.restock_req = 1'b0;
      tick();
      check("bad restock ack drop", {7'd0, ifc.restock_ack}, 8'd0);

      // Cookie restock +2 colliding with a cookie sale in R_APPLY
      ifc.restock_req  = 1'b1;
      ifc.restock_code = 8'hE8;
      ifc.restock_qty  = 3'd2;
      ifc.item_code    = 8'hE8;
      tick();                        // now in R_APPLY
      ifc.decrement = 1'b1;
      tick();
      check("cookie sale first cs_c", {5'd0, ifc.cs_c}, 8'd4);
      check("cookie sale first ack", {7'd0, ifc.restock_ack}, 8'd0);
      check("cookie sale sold", ifc.sold_total, 8'd7);
      tick();
      check("cookie restock cs_c", {5'd0, ifc.cs_c}, 8'd6);
      check("cookie restock ack", {7'd0, ifc.restock_ack}, 8'd1);
      ifc.decrement = 1'b0;
      tick();
      check("cookie ack held", {7'd0, ifc.restock_ack}, 8'd1);

      // Reset during R_ACK
      #3 reset = 1'b0;
      #1;
      check("mid reset ack", {7'd0, ifc.restock_ack}, 8'd0);
      check_counts("mid reset", 3'd5, 3'd5, 3'd5, 3'd5);
      check("mid reset sold", ifc.sold_total, 8'd0);
      tick();
      reset = 1'b1;

      // Request still held: new handshake, with a chips sale in the same cycle
      tick();                        // now in R_APPLY
      ifc.item_code = 8'hA2;
      ifc.decrement = 1'b1;
      tick();
      ifc.decrement = 1'b0;
      check("rehandshake cs_c", {5'd0, ifc.cs_c}, 8'd7);
      check("rehandshake cs_pc", {5'd0, ifc.cs_pc}, 8'd4);
      check("rehandshake sold", ifc.sold_total, 8'd1);
      check("rehandshake ack", {7'd0, ifc.restock_ack}, 8'd1);
      ifc.restock_req = 1'b0;
      tick();
      check("rehandshake ack drop", {7'd0, ifc.restock_ack}, 8'd0);
      check("final low_stock", {4'd0, ifc.low_stock}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
